// File: rtl/ex_result_arbiter.sv
// Per-source result FIFOs drained round-robin onto one registered EX->EXWB bus.
// Optional: EX_RESULT_ARB_JUMP_PRIO_EN gives the jump unit strict priority over the others.

`ifndef INST_TAG_WIDTH
`define INST_TAG_WIDTH 6
`endif
`ifndef TAG_INVALID
`define TAG_INVALID {`INST_TAG_WIDTH{1'b1}}
`endif
`ifndef EX_JUMP_UNIT
`define EX_JUMP_UNIT 2
`endif

module ex_result_arbiter #(
  parameter int  N_SRC  = 3,
  parameter int  DEPTH  = 4,
  parameter int  DATA_W = 32,
  localparam int SW     = $clog2(N_SRC)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [N_SRC-1:0][`INST_TAG_WIDTH-1:0]  src_tag,
  input  logic [N_SRC-1:0][DATA_W-1:0]           src_data,
  output logic [N_SRC-1:0]                       src_full,
  input  logic                                   out_stall,
  output logic [`INST_TAG_WIDTH-1:0]             out_tag,
  output logic [SW-1:0]                          out_src,
  output logic [DATA_W-1:0]                      out_data,
  output logic                                   err_ovf
);

  localparam int                TW       = `INST_TAG_WIDTH;
  localparam int                PW       = $clog2(DEPTH);
  localparam int                CW       = PW + 1;
  localparam int                JUMP     = `EX_JUMP_UNIT;
  localparam logic [TW-1:0]     TAG_INV  = `TAG_INVALID;
  localparam logic [SW-1:0]     LAST_RST = SW'(N_SRC - 1);
  localparam logic [CW-1:0]     CNT_FULL = CW'(DEPTH);

  logic [TW-1:0]     tag_mem_q [N_SRC][DEPTH];
  logic [DATA_W-1:0] dat_mem_q [N_SRC][DEPTH];

  logic [PW-1:0] wr_ptr_q [N_SRC];
  logic [PW-1:0] wr_ptr_d [N_SRC];
  logic [PW-1:0] rd_ptr_q [N_SRC];
  logic [PW-1:0] rd_ptr_d [N_SRC];
  logic [CW-1:0] cnt_q    [N_SRC];
  logic [CW-1:0] cnt_d    [N_SRC];

  logic [N_SRC-1:0] req;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] rr_cand;

  logic [SW-1:0]     last_q, last_d;
  logic [TW-1:0]     out_tag_q, out_tag_d;
  logic [SW-1:0]     out_src_q, out_src_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              err_ovf_q, err_ovf_d;

  logic          rr_vld;
  logic [SW-1:0] rr_idx;
  logic [SW-1:0] rr_cur;
  logic          jump_win;
  logic          gnt_vld;
  logic [SW-1:0] gnt_idx;
  logic          take;

  // Full is judged on the pre-edge count, so a same-cycle pop never frees a slot for a push.
  always_comb begin
    req      = '0;
    push     = '0;
    cand     = '0;
    src_full = '0;
    for (int i = 0; i < N_SRC; i++) begin
      req[i]      = (src_tag[i] != TAG_INV);
      src_full[i] = (cnt_q[i] == CNT_FULL);
      push[i]     = req[i] & ~src_full[i] & ~flush;
      cand[i]     = (cnt_q[i] != '0);
    end
  end

  always_comb begin
    rr_cand  = cand;
    jump_win = 1'b0;
`ifdef EX_RESULT_ARB_JUMP_PRIO_EN
    rr_cand[JUMP] = 1'b0;
    jump_win      = cand[JUMP];
`endif
    rr_vld = 1'b0;
    rr_idx = '0;
    rr_cur = last_q;
    for (int k = 0; k < N_SRC; k++) begin
      rr_cur = (rr_cur == LAST_RST) ? '0 : rr_cur + SW'(1);
      if (!rr_vld && rr_cand[rr_cur]) begin
        rr_vld = 1'b1;
        rr_idx = rr_cur;
      end
    end
    gnt_vld = jump_win | rr_vld;
    gnt_idx = jump_win ? SW'(JUMP) : rr_idx;
  end

  assign take = ~flush & ~out_stall & gnt_vld;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_SRC; i++) begin
      pop[i]      = take && (gnt_idx == SW'(i));
      wr_ptr_d[i] = wr_ptr_q[i] + PW'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
      cnt_d[i]    = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      if (flush) begin
        wr_ptr_d[i] = '0;
        rd_ptr_d[i] = '0;
        cnt_d[i]    = '0;
      end
    end
  end

  always_comb begin
    out_tag_d  = out_tag_q;
    out_src_d  = out_src_q;
    out_data_d = out_data_q;
    last_d     = last_q;
    err_ovf_d  = err_ovf_q | ((|(req & src_full)) & ~flush);
    if (flush) begin
      out_tag_d = TAG_INV;
      last_d    = LAST_RST;
    end else if (!out_stall) begin
      if (gnt_vld) begin
        out_tag_d  = tag_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
        out_data_d = dat_mem_q[gnt_idx][rd_ptr_q[gnt_idx]];
        out_src_d  = gnt_idx;
        // Jump grants bypass the rotation, so they leave the pointer alone.
        if (!jump_win) last_d = gnt_idx;
      end else begin
        out_tag_d = TAG_INV;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      last_q     <= LAST_RST;
      out_tag_q  <= TAG_INV;
      out_src_q  <= '0;
      out_data_q <= '0;
      err_ovf_q  <= 1'b0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      last_q     <= last_d;
      out_tag_q  <= out_tag_d;
      out_src_q  <= out_src_d;
      out_data_q <= out_data_d;
      err_ovf_q  <= err_ovf_d;
    end
  end

  // Payload storage needs no reset: counts gate every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_SRC; i++) begin
      if (push[i]) begin
        tag_mem_q[i][wr_ptr_q[i]] <= src_tag[i];
        dat_mem_q[i][wr_ptr_q[i]] <= src_data[i];
      end
    end
  end

  assign out_tag  = out_tag_q;
  assign out_src  = out_src_q;
  assign out_data = out_data_q;
  assign err_ovf  = err_ovf_q;

endmodule

// File: tb/tb_ex_result_arbiter.sv
// Directed vector table plus hand-written flush and async-reset sequences for ex_result_arbiter.

module tb_ex_result_arbiter;

  localparam logic [5:0] TI = 6'h3f;

  logic              clk;
  logic              rst;
  logic              flush;
  logic [2:0][5:0]   src_tag;
  logic [2:0][31:0]  src_data;
  logic [2:0]        src_full;
  logic              out_stall;
  logic [5:0]        out_tag;
  logic [1:0]        out_src;
  logic [31:0]       out_data;
  logic              err_ovf;

  ex_result_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .src_tag   (src_tag),
    .src_data  (src_data),
    .src_full  (src_full),
    .out_stall (out_stall),
    .out_tag   (out_tag),
    .out_src   (out_src),
    .out_data  (out_data),
    .err_ovf   (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  t0, t1, t2;
    logic        stall, fl;
    logic [5:0]  etag;
    logic [1:0]  esrc;
    logic [31:0] edata;
    logic [2:0]  efull;
    logic        eovf;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] prev_data;
  int          n_cmp;
  int          n_bad;

  // Payload of a result: source in the top byte, tag+12 below (src 0 tag 5 -> 0x11).
  function automatic logic [31:0] fdat(input int s, input logic [5:0] t);
    return (32'(s) << 24) | (32'(t) + 32'd12);
  endfunction

  task automatic add(input logic [5:0] a, b, c, input logic st, fl,
                     input logic [5:0] et, input logic [1:0] es,
                     input logic [2:0] ef, input logic eo);
    vec_t v;
    v.t0 = a; v.t1 = b; v.t2 = c; v.stall = st; v.fl = fl;
    v.etag = et; v.esrc = es; v.efull = ef; v.eovf = eo;
    if (et != TI) prev_data = fdat(int'(es), et);
    v.edata = prev_data;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [5:0] a, b, c, input logic st, fl);
    src_tag[0]  = a;  src_data[0] = fdat(0, a);
    src_tag[1]  = b;  src_data[1] = fdat(1, b);
    src_tag[2]  = c;  src_data[2] = fdat(2, c);
    out_stall   = st;
    flush       = fl;
  endtask

  task automatic step(input logic [5:0] a, b, c, input logic st, fl);
    drive(a, b, c, st, fl);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", nm, idx, got, exp);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    prev_data = '0;
    rst = 1'b0;
    drive(TI, TI, TI, 1'b0, 1'b0);

    // single push, latency and bubble
    add(6'd5, TI, TI, 0, 0,  TI,    2'd0, 3'b000, 0);
    add(TI,   TI, TI, 0, 0,  6'd5,  2'd0, 3'b000, 0);
    add(TI,   TI, TI, 0, 0,  TI,    2'd0, 3'b000, 0);
    // flush restores the pointer so source 0 leads the next round
    add(TI,   TI, TI, 0, 1,  TI,    2'd0, 3'b000, 0);
    add(6'd1, 6'd2, 6'd3,  0, 0, TI,    2'd0, 3'b000, 0);
    add(6'd8, 6'd9, 6'd10, 0, 0, 6'd1,  2'd0, 3'b000, 0);
    add(TI,   TI, TI, 0, 0,  6'd2,  2'd1, 3'b000, 0);
    add(TI,   TI, TI, 0, 0,  6'd3,  2'd2, 3'b000, 0);
    add(TI,   TI, TI, 0, 0,  6'd8,  2'd0, 3'b000, 0);
    add(TI,   TI, TI, 0, 0,  6'd9,  2'd1, 3'b000, 0);
    add(TI,   TI, TI, 0, 0,  6'd10, 2'd2, 3'b000, 0);
    add(TI,   TI, TI, 0, 0,  TI,    2'd2, 3'b000, 0);
    // fill ALU FIFO under stall, overflow, then drain in order
    add(6'd11, TI, TI, 1, 0, TI,    2'd2, 3'b000, 0);
    add(6'd12, TI, TI, 1, 0, TI,    2'd2, 3'b000, 0);
    add(6'd13, TI, TI, 1, 0, TI,    2'd2, 3'b000, 0);
    add(6'd14, TI, TI, 1, 0, TI,    2'd2, 3'b001, 0);
    add(6'd15, TI, TI, 1, 0, TI,    2'd2, 3'b001, 1);
    add(TI,   TI, TI, 0, 0,  6'd11, 2'd0, 3'b000, 1);
    add(TI,   TI, TI, 0, 0,  6'd12, 2'd0, 3'b000, 1);
    add(TI,   TI, TI, 0, 0,  6'd13, 2'd0, 3'b000, 1);
    add(TI,   TI, TI, 0, 0,  6'd14, 2'd0, 3'b000, 1);
    add(TI,   TI, TI, 0, 0,  TI,    2'd0, 3'b000, 1);
    // output holds tag 7 across a stall
    add(TI, 6'd7,  TI, 0, 0, TI,    2'd0, 3'b000, 1);
    add(TI, 6'd16, TI, 0, 0, 6'd7,  2'd1, 3'b000, 1);
    add(TI, TI, 6'd17, 1, 0, 6'd7,  2'd1, 3'b000, 1);
    add(TI, TI, TI,    1, 0, 6'd7,  2'd1, 3'b000, 1);
    add(TI, TI, TI,    1, 0, 6'd7,  2'd1, 3'b000, 1);
    add(TI, TI, TI,    0, 0, 6'd17, 2'd2, 3'b000, 1);
    add(TI, TI, TI,    0, 0, 6'd16, 2'd1, 3'b000, 1);
    add(TI, TI, TI,    0, 0, TI,    2'd1, 3'b000, 1);
    // ALU and jump queued two each
    add(TI, TI, TI,       0, 1, TI, 2'd1, 3'b000, 1);
    add(6'd20, TI, 6'd22, 1, 0, TI, 2'd1, 3'b000, 1);
    add(6'd21, TI, 6'd23, 1, 0, TI, 2'd1, 3'b000, 1);
`ifdef EX_RESULT_ARB_JUMP_PRIO_EN
    add(TI, TI, TI, 0, 0, 6'd22, 2'd2, 3'b000, 1);
    add(TI, TI, TI, 0, 0, 6'd23, 2'd2, 3'b000, 1);
    add(TI, TI, TI, 0, 0, 6'd20, 2'd0, 3'b000, 1);
    add(TI, TI, TI, 0, 0, 6'd21, 2'd0, 3'b000, 1);
    add(TI, TI, TI, 0, 0, TI,    2'd0, 3'b000, 1);
`else
    add(TI, TI, TI, 0, 0, 6'd20, 2'd0, 3'b000, 1);
    add(TI, TI, TI, 0, 0, 6'd22, 2'd2, 3'b000, 1);
    add(TI, TI, TI, 0, 0, 6'd21, 2'd0, 3'b000, 1);
    add(TI, TI, TI, 0, 0, 6'd23, 2'd2, 3'b000, 1);
    add(TI, TI, TI, 0, 0, TI,    2'd2, 3'b000, 1);
`endif

    // reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out_tag",  0, 32'(out_tag),  32'(TI));
    chk("rst_out_src",  0, 32'(out_src),  32'd0);
    chk("rst_out_data", 0, out_data,      32'd0);
    chk("rst_src_full", 0, 32'(src_full), 32'd0);
    chk("rst_err_ovf",  0, 32'(err_ovf),  32'd0);
    rst = 1'b1;

    for (int v = 0; v < vecs.size(); v++) begin
      step(vecs[v].t0, vecs[v].t1, vecs[v].t2, vecs[v].stall, vecs[v].fl);
      chk("out_tag",  v, 32'(out_tag),  32'(vecs[v].etag));
      chk("out_src",  v, 32'(out_src),  32'(vecs[v].esrc));
      chk("out_data", v, out_data,      vecs[v].edata);
      chk("src_full", v, 32'(src_full), 32'(vecs[v].efull));
      chk("err_ovf",  v, 32'(err_ovf),  32'(vecs[v].eovf));
    end

    // two entries per source, then a stalled flush with concurrent pushes
    step(6'd30, 6'd31, 6'd32, 1'b1, 1'b0);
    chk("fl_hold_tag", 0, 32'(out_tag), 32'(TI));
    step(6'd33, 6'd34, 6'd35, 1'b0, 1'b0);
`ifdef EX_RESULT_ARB_JUMP_PRIO_EN
    chk("fl_pre_tag", 0, 32'(out_tag), 32'd32);
`else
    chk("fl_pre_tag", 0, 32'(out_tag), 32'd30);
`endif
    step(6'd40, 6'd41, 6'd42, 1'b1, 1'b1);
    chk("fl_out_tag",  0, 32'(out_tag),  32'(TI));
    chk("fl_src_full", 0, 32'(src_full), 32'd0);
    chk("fl_err_ovf",  0, 32'(err_ovf),  32'd1);
    for (int c = 1; c <= 6; c++) begin
      step(TI, TI, TI, 1'b0, 1'b0);
      chk("fl_drain_tag", c, 32'(out_tag), 32'(TI));
    end

    // async reset mid-cycle, away from any edge
    #2;
    rst = 1'b0;
    #1;
    chk("arst_err_ovf",  0, 32'(err_ovf),  32'd0);
    chk("arst_out_tag",  0, 32'(out_tag),  32'(TI));
    chk("arst_out_data", 0, out_data,      32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
